inst_sram_loader: RTL

Boot-time program loader that sits directly upstream of mycpu_top on its instruction-SRAM write port. It accepts a stream of 32-bit machine-code words over a valid/ready interface and writes them to consecutive inst SRAM word addresses, holding the core in reset meanwhile. After the last word plus a fixed settle delay, it releases the core reset and enables instruction fetch. This replaces hand-driven inst_sram_wen/waddr/wdata sequencing.

---
 rtl/inst_sram_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inst_sram_loader.sv
`timescale 1ns/1ps
// inst_sram_loader
// Boot-time program loader in front of mycpu_top's instruction-SRAM write port.
// It takes a valid/ready stream of instruction words and writes each one to the
// next inst SRAM word address, starting at BASE_ADDR. The core is held in reset
// during the load and is released BOOT_DELAY cycles after the final write.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   load_start/prog_len load request and word count (sampled in IDLE only)
//   s_valid/s_ready/s_data  instruction word stream
//   inst_sram_wen/waddr/wdata  SRAM write port (write appears 1 cycle after accept)
//   inst_sram_en_toif   fetch enable to the core
//   cpu_reset           core reset, active-high
//   load_done/load_err  sticky status flags
//   word_cnt            words written in the current load
//
// state  | meaning
// IDLE   | waiting for load_start
// LOAD   | accepting stream words, one SRAM write per accepted word
// SETTLE | last word written, counting down to core release
// RUN    | core out of reset and fetching; only reset leaves
// ERR    | illegal prog_len requested; only reset leaves

module inst_sram_loader #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BASE_ADDR  = 1,
    parameter int unsigned MAX_WORDS  = 1024,
    parameter int unsigned BOOT_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [15:0]       prog_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              inst_sram_wen,
    output logic [ADDR_W-1:0] inst_sram_waddr,
    output logic [DATA_W-1:0] inst_sram_wdata,
    output logic              inst_sram_en_toif,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);
    localparam int                DLY_W   = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    // The first SETTLE cycle is the final write cycle itself, hence the -1.
    localparam logic [DLY_W-1:0]  DLY_INIT = DLY_W'(BOOT_DELAY - 1);

    state_t            state_q;
    logic [15:0]       prog_len_q;
    logic [15:0]       word_cnt_q;
    logic [DLY_W-1:0]  dly_q;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cpu_reset_q;
    logic              en_toif_q;
    logic              done_q;
    logic              err_q;

    logic accept;
    logic last_word;
    logic len_ok;

    assign s_ready   = (state_q == S_LOAD);
    assign accept    = s_valid & s_ready;
    // word_cnt_q already counts every earlier accept, so this is the pre-increment index.
    assign last_word = ((word_cnt_q + 16'd1) == prog_len_q);
    assign len_ok    = (prog_len != 16'd0) && ({1'b0, prog_len} <= MAX_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prog_len_q  <= '0;
            word_cnt_q  <= '0;
            dly_q       <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= BASE;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            en_toif_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            prog_len_q <= prog_len;
                            word_cnt_q <= '0;
                            state_q    <= S_LOAD;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        wen_q      <= 1'b1;
                        waddr_q    <= BASE + ADDR_W'(word_cnt_q);
                        wdata_q    <= s_data;
                        word_cnt_q <= word_cnt_q + 16'd1;
                        if (last_word) begin
                            dly_q   <= DLY_INIT;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (dly_q == '0) begin
                        cpu_reset_q <= 1'b0;
                        en_toif_q   <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
                S_RUN, S_ERR: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign inst_sram_wen     = wen_q;
    assign inst_sram_waddr   = waddr_q;
    assign inst_sram_wdata   = wdata_q;
    assign inst_sram_en_toif = en_toif_q;
    assign cpu_reset         = cpu_reset_q;
    assign load_done         = done_q;
    assign load_err          = err_q;
    assign word_cnt          = word_cnt_q;

endmodule
